instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Parametrised, loadable instruction memory for the processor fetch stage. It replaces a fixed, initial-block-programmed ROM with a synchronous-read RAM. The RAM is filled at run time through a streaming load port and read by the fetch stage through a request/valid handshake. It sits between the PC register and the IF/ID pipeline register. While a program is streaming in from the testbench or host loader, the block stalls fetch.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 8, fetch/load address width
- DEPTH, 256, number of words (DEPTH ≤ 2^ADDR_W)
- NOP_WORD, 0, word returned for out-of-range fetches and initial contents

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  fetch request from PC stage
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  block accepts fetches (state RUN)
- fetch_valid  out  1  data_out holds a fresh fetch result
- data_out  out  DATA_W  fetched instruction
- fault  out  1  qualifies fetch_valid; last fetch address ≥ DEPTH
- load_start  in  1  pulse: begin streaming a new program at word 0
- load_valid  in  1  load_data valid this cycle
- load_last  in  1  with load_valid: final word of program
- load_data  in  DATA_W  program word
- load_ready  out  1  block accepts load words (state LOAD)
- load_done  out  1  one-cycle pulse: load finished
- load_count  out  ADDR_W+1  words written by the most recent load

## Operation
- Reset values:
  - state = RUN; write pointer = 0
  - fetch_valid, fault, load_done = 0; data_out = NOP_WORD; load_count = 0
  - Memory contents are not altered by reset; they are initialised to NOP_WORD at time zero only.
- States RUN and LOAD:
  - RUN: fetch_ready = 1, load_ready = 0.
  - LOAD: fetch_ready = 0, load_ready = 1.
- RUN → LOAD on load_start:
  - Write pointer cleared to 0 and load_count cleared to 0.
  - A fetch accepted in the same cycle completes normally.
- In LOAD, each cycle with load_valid:
  - mem[ptr] ← load_data; ptr increments; load_count increments.
- LOAD → RUN occurs on the first of:
  - load_valid && load_last, or
  - a write to ptr = DEPTH−1 (auto-terminate; no wrap-around).
  - load_done pulses in the cycle after the final write.
- load_start while in LOAD: restarts the load at ptr 0. Words already written stay in memory.
- Fetch accept condition: fetch_req && fetch_ready.
  - In-range address: data_out ← mem[fetch_addr], fault ← 0.
  - Address ≥ DEPTH: data_out ← NOP_WORD, fault ← 1.
- Cycles with no accepted fetch: fetch_valid = 0, fault = 0, data_out holds its last value.
- fetch_req while fetch_ready = 0: ignored, not queued. The requester must hold the request until it sees ready.
- Read-during-write cannot occur because fetch is disabled in LOAD.

## Timing
- Fetch latency is 1 cycle: an accept at edge N gives fetch_valid, data_out and fault valid after edge N+1. Throughput is one fetch per cycle.
- Load: one word per cycle at full rate.
- load_ready and fetch_ready are pure functions of the state register. Neither depends combinationally on any input.
- The first accepted fetch can occur in the cycle after load_done asserts. It returns the newly written data.
- Reset asserted mid-load:
  - Returns to RUN next edge; no load_done.
  - Words written so far remain; load_count reads 0.

## Structure
- Shared package `imem_pkg`:
  - state enum {RUN, LOAD}
  - default DATA_W/ADDR_W/DEPTH constants
  - NOP_WORD constant, shared with the decoder's bubble encoding
- One natural sub-module, `imem_ram_1r1w`: DEPTH×DATA_W array with synchronous write and registered read, inferred as block RAM.
- The control FSM, write pointer and fault logic stay in the top module.

## Test plan
- Reset, then fetch addresses 0..3 → fetch_valid = 1 one cycle after each request; data_out = 0; fault = 0.
- load_start, then stream 0x71041000, 0x5104FC00, 0x41420C00 with load_last on the third word:
  - load_done pulses once; load_count = 3.
  - Fetches of 0..2 return those words in order, one per cycle.
- fetch_req held during LOAD → fetch_ready = 0 and no fetch_valid until load_done. The first fetch after that returns the new data.
- DEPTH = 16 instance, fetch_addr = 20 → data_out = NOP_WORD, fault = 1 for one cycle.
- DEPTH = 16, stream 20 words without load_last:
  - Auto-exit after the 16th word; load_count = 16.
  - Words 17–20 are ignored (load_ready = 0).
  - mem[0] is not overwritten.
- Assert reset after 2 of 5 load words → state RUN next cycle; load_done never pulses; fetch of 1 returns the second streamed word.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared states and default parameters for the loadable instruction memory
package imem_pkg;
  typedef enum logic {RUN, LOAD} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF = 256;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
endpackage

// File: rtl/imem_ram_1r1w.sv
// imem_ram_1r1w: DEPTH x DATA_W block RAM with synchronous write and registered read
module imem_ram_1r1w import imem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 8,
  parameter logic [DATA_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT};
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction RAM with fetch handshake and streaming load port
module instr_mem_loadable import imem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic accept, oor, we, last_wr, nop_sel;
  logic [DATA_W-1:0] rdata;
  assign fetch_ready = state == RUN;
  assign load_ready = state == LOAD;
  assign accept = fetch_req && fetch_ready;
  assign oor = {1'b0, fetch_addr} >= (ADDR_W+1)'(DEPTH);
  assign we = load_ready && load_valid && !load_start;
  assign last_wr = we && (load_last || ptr == ADDR_W'(DEPTH - 1));
  assign data_out = nop_sel ? NOP_WORD : rdata;
  always_comb state_d = load_start ? LOAD : last_wr ? RUN : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      ptr <= '0;
      load_count <= '0;
      load_done <= 1'b0;
      fetch_valid <= 1'b0;
      fault <= 1'b0;
      nop_sel <= 1'b1;
    end else begin
      state <= state_d;
      ptr <= load_start ? '0 : we ? ptr + 1'b1 : ptr;
      load_count <= load_start ? '0 : we ? load_count + 1'b1 : load_count;
      load_done <= last_wr;
      fetch_valid <= accept;
      fault <= accept && oor;
      if (accept) nop_sel <= oor;
    end
  end
  imem_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .INIT(NOP_WORD)) u_ram (
    .clk(clock),
    .we(we),
    .waddr(ptr[AW-1:0]),
    .wdata(load_data),
    .re(accept && !oor),
    .raddr(fetch_addr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: scoreboard bench with a spec-level model of the loadable instruction memory
module tb_instr_mem_loadable;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0;
  typedef struct packed {logic f; logic [31:0] d;} exp_t;
  logic clock = 0, reset = 1;
  logic fetch_req = 0, load_start = 0, load_valid = 0, load_last = 0;
  logic [7:0] fetch_addr = 0;
  logic [31:0] load_data = 0;
  logic fetch_ready, fetch_valid, fault, load_ready, load_done;
  logic [31:0] data_out;
  logic [8:0] load_count;
  int total = 0, bad = 0;
  exp_t exp_q[$];
  logic [31:0] mem_m [DEPTH] = '{default: NOP};
  bit mrun = 1, mdone = 0;
  int mptr = 0, mcount = 0;
  logic [31:0] last_data = NOP;
  instr_mem_loadable #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .data_out(data_out), .fault(fault),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    bit done_next = 0;
    if (reset) begin
      mrun = 1;
      mcount = 0;
    end else begin
      if (fetch_req && mrun)
        exp_q.push_back('{f: fetch_addr >= DEPTH, d: fetch_addr < DEPTH ? mem_m[fetch_addr[3:0]] : NOP});
      if (load_start) begin
        mrun = 0;
        mptr = 0;
        mcount = 0;
      end else if (!mrun && load_valid) begin
        mem_m[mptr] = load_data;
        mcount++;
        if (load_last || mptr == DEPTH - 1) begin
          mrun = 1;
          done_next = 1;
        end
        mptr++;
      end
    end
    @(posedge clock);
    #1;
    mdone = done_next;
    chk("load_done", 32'(load_done), 32'(mdone));
    chk("fetch_ready", 32'(fetch_ready), 32'(mrun));
    chk("load_ready", 32'(load_ready), 32'(!mrun));
    chk("load_count", 32'(load_count), 32'(mcount));
  endtask
  task automatic load(input int n, input bit use_last, input bit gaps);
    load_start = 1;
    step();
    load_start = 0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(3) == 0) step();
      load_valid = 1;
      load_data = $urandom;
      load_last = use_last && i == n - 1;
      step();
      load_valid = 0;
      load_last = 0;
    end
    step();
    step();
  endtask
  task automatic fetch(input int a);
    fetch_req = 1;
    fetch_addr = 8'(a);
    step();
    fetch_req = 0;
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (reset) last_data = NOP;
    else if (fetch_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=1 exp=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_data", data_out, e.d);
        chk("fetch_fault", 32'(fault), 32'(e.f));
        last_data = e.d;
      end
    end else begin
      chk("idle_fault", 32'(fault), 0);
      chk("idle_hold", data_out, last_data);
    end
  end
  initial begin
    step();
    step();
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_data", data_out, NOP);
    reset = 0;
    for (int a = 0; a < 4; a++) fetch(a);
    step();
    load_start = 1;
    step();
    load_start = 0;
    load_valid = 1;
    load_data = 32'h7104_1000;
    step();
    load_data = 32'h5104_FC00;
    step();
    load_data = 32'h4142_0C00;
    load_last = 1;
    step();
    load_valid = 0;
    load_last = 0;
    chk("count3", 32'(load_count), 3);
    for (int a = 0; a < 3; a++) fetch(a);
    step();
    fetch_req = 1;
    fetch_addr = 1;
    load(4, 1, 0);
    step();
    fetch_req = 0;
    step();
    fetch(20);
    fetch(2);
    step();
    load(20, 0, 0);
    chk("count16", 32'(load_count), 16);
    fetch(0);
    fetch(15);
    step();
    load_start = 1;
    step();
    load_start = 0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1;
      load_data = $urandom;
      step();
    end
    load_valid = 0;
    reset = 1;
    step();
    reset = 0;
    step();
    fetch(1);
    step();
    load_start = 1;
    step();
    load_start = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1;
      load_data = $urandom;
      step();
    end
    load_valid = 0;
    load(2, 1, 0);
    for (int a = 0; a < 4; a++) fetch(a);
    repeat (6) begin
      load($urandom_range(1, 20), 1'($urandom_range(1)), 1);
      repeat (15) begin
        fetch_req = 1'($urandom_range(1));
        fetch_addr = 8'($urandom_range(23));
        step();
      end
      fetch_req = 0;
      step();
    end
    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
